// File: rtl/cnn_pkg.sv
// Shared types and frame-size helpers for the CNN frame sequencer.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam int NUM_COEF  = 9;
  localparam int DEF_IMG_N = 6;
  localparam int DEF_K     = 3;
  localparam int DEF_P     = 2;

  function automatic int pix_cnt_f(input int img_n);
    return img_n * img_n;
  endfunction

  // Pooled outputs per frame: valid-conv side divided by the pool window, squared.
  function automatic int out_cnt_f(input int img_n, input int k, input int p);
    return ((img_n - k + 1) / p) * ((img_n - k + 1) / p);
  endfunction

  localparam int PIX_CNT = pix_cnt_f(DEF_IMG_N);
  localparam int OUT_CNT = out_cnt_f(DEF_IMG_N, DEF_K, DEF_P);

endpackage

// File: rtl/cnn_coef_regs.sv
// Nine-entry write-indexed 3x3 kernel coefficient register file, flat outputs.
// Write lands one cycle after wr_en; contents survive abort, cleared only by reset.
module cnn_coef_regs
  import cnn_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [3:0]          wr_idx,
  input  logic [N-1:0]        wr_data,
  output logic signed [N-1:0] k00,
  output logic signed [N-1:0] k01,
  output logic signed [N-1:0] k02,
  output logic signed [N-1:0] k10,
  output logic signed [N-1:0] k11,
  output logic signed [N-1:0] k12,
  output logic signed [N-1:0] k20,
  output logic signed [N-1:0] k21,
  output logic signed [N-1:0] k22
);

  logic [N-1:0] coef [NUM_COEF];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_COEF; i++) coef[i] <= '0;
    end else if (wr_en && (wr_idx < 4'(NUM_COEF))) begin
      coef[wr_idx] <= wr_data;
    end
  end

  assign k00 = coef[0];
  assign k01 = coef[1];
  assign k02 = coef[2];
  assign k10 = coef[3];
  assign k11 = coef[4];
  assign k12 = coef[5];
  assign k20 = coef[6];
  assign k21 = coef[7];
  assign k22 = coef[8];

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame controller: loads kernel, clears and streams IMG_N^2 pixels, counts pooled results.
// Pixel to acc_en/acc_pixel is one cycle; pix_ready only in STREAM, w_ready only in LOAD_K.
module cnn_frame_sequencer
  import cnn_pkg::*;
#(
  parameter int N       = 16,
  parameter int IMG_N   = 6,
  parameter int K       = 3,
  parameter int P       = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                reuse_k,
  input  logic                abort,
  input  logic                w_valid,
  input  logic [N-1:0]        w_data,
  output logic                w_ready,
  input  logic                pix_valid,
  input  logic [N-1:0]        pix_data,
  output logic                pix_ready,
  output logic                acc_clr,
  output logic                acc_en,
  output logic [N-1:0]        acc_pixel,
  output logic signed [N-1:0] k00,
  output logic signed [N-1:0] k01,
  output logic signed [N-1:0] k02,
  output logic signed [N-1:0] k10,
  output logic signed [N-1:0] k11,
  output logic signed [N-1:0] k12,
  output logic signed [N-1:0] k20,
  output logic signed [N-1:0] k21,
  output logic signed [N-1:0] k22,
  input  logic                acc_valid,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int PIXN = pix_cnt_f(IMG_N);
  localparam int OUTN = out_cnt_f(IMG_N, K, P);
  localparam int PCW  = $clog2(PIXN + 1);
  localparam int RCW  = $clog2(OUTN + 1);
  localparam int TCW  = $clog2(TIMEOUT + 1);

  state_t         state, state_nx;
  logic [3:0]     widx;
  logic [PCW-1:0] pcnt;
  logic [RCW-1:0] rcnt;
  logic [TCW-1:0] timer;
  logic           w_hs, pix_hs, abort_go, rcnt_full, timed_out, counting;

  assign w_ready   = (state == LOAD_K);
  assign pix_ready = (state == STREAM);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign w_hs      = w_valid & w_ready;
  assign pix_hs    = pix_valid & pix_ready;
  assign abort_go  = abort & busy;
  assign rcnt_full = (rcnt == RCW'(OUTN));
  assign timed_out = (timer == TCW'(TIMEOUT));
  assign counting  = (state == STREAM) || (state == DRAIN) || (state == DONE);

  always_comb begin
    state_nx = state;
    if (abort_go) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = reuse_k ? CLEAR : LOAD_K;
        LOAD_K:  if (w_hs && (widx == 4'(NUM_COEF - 1))) state_nx = CLEAR;
        CLEAR:   state_nx = STREAM;
        STREAM:  if (pix_hs && (pcnt == PCW'(PIXN - 1))) state_nx = DRAIN;
        DRAIN:   if (rcnt_full) state_nx = DONE;
                 else if (timed_out) state_nx = IDLE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      widx      <= '0;
      pcnt      <= '0;
      rcnt      <= '0;
      timer     <= '0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      acc_pixel <= '0;
      err       <= 1'b0;
    end else begin
      state   <= state_nx;
      // Pulse on entry to CLEAR, and once more on the way out of an aborted frame.
      acc_clr <= (state_nx == CLEAR) || abort_go;
      acc_en  <= pix_hs;
      if (pix_hs) acc_pixel <= pix_data;

      if ((state == IDLE) && start) begin
        err  <= 1'b0;
        widx <= '0;
      end
      if (w_hs) widx <= widx + 1'b1;

      if (state == CLEAR) begin
        pcnt  <= '0;
        rcnt  <= acc_valid ? RCW'(1) : '0;
        timer <= '0;
      end else begin
        if (pix_hs) pcnt <= pcnt + 1'b1;
        if (acc_valid && counting && !rcnt_full) rcnt <= rcnt + 1'b1;
        if (state == DRAIN) timer <= acc_valid ? '0 : timer + 1'b1;
      end

      if ((state == DRAIN) && !rcnt_full && timed_out && !abort_go) err <= 1'b1;
    end
  end

  cnn_coef_regs #(.N(N)) u_coef (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_hs),
    .wr_idx  (widx),
    .wr_data (w_data),
    .k00     (k00),
    .k01     (k01),
    .k02     (k02),
    .k10     (k10),
    .k11     (k11),
    .k12     (k12),
    .k20     (k20),
    .k21     (k21),
    .k22     (k22)
  );

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboarded bench for cnn_frame_sequencer with a behavioural source and accelerator.
module tb_cnn_frame_sequencer;

  localparam int N         = 16;
  localparam int IMG_N     = 6;
  localparam int KS        = 3;
  localparam int PW        = 2;
  localparam int TMO       = 64;
  localparam int PIX_TOTAL = IMG_N * IMG_N;
  localparam int RES_TOTAL = ((IMG_N - KS + 1) / PW) * ((IMG_N - KS + 1) / PW);

  logic         clk, rst, start, reuse_k, abort;
  logic         w_valid, w_ready, pix_valid, pix_ready;
  logic [N-1:0] w_data, pix_data, acc_pixel;
  logic         acc_clr, acc_en, acc_valid, busy, done, err;
  logic [N-1:0] k00, k01, k02, k10, k11, k12, k20, k21, k22;
  logic [N-1:0] kq [9];

  assign kq[0] = k00; assign kq[1] = k01; assign kq[2] = k02;
  assign kq[3] = k10; assign kq[4] = k11; assign kq[5] = k12;
  assign kq[6] = k20; assign kq[7] = k21; assign kq[8] = k22;

  cnn_frame_sequencer #(.N(N), .IMG_N(IMG_N), .K(KS), .P(PW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .reuse_k(reuse_k), .abort(abort),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .acc_clr(acc_clr), .acc_en(acc_en), .acc_pixel(acc_pixel),
    .k00(k00), .k01(k01), .k02(k02), .k10(k10), .k11(k11), .k12(k12),
    .k20(k20), .k21(k21), .k22(k22),
    .acc_valid(acc_valid), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard state: pixels the source handed over, and coefficients it wrote.
  logic [N-1:0] exp_q [$];
  logic [N-1:0] exp_k [9];
  int acc_en_cnt = 0, clr_cnt = 0, done_cnt = 0, wr_cnt = 0;
  int cyc = 0, last_av_cyc = 0;
  logic last_hs = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      last_hs = 1'b0;
    end else begin
      if (acc_en) begin
        acc_en_cnt++;
        if (exp_q.size() == 0) chk("acc_en_without_pixel", 1, 0);
        else chk("acc_pixel", acc_pixel, exp_q.pop_front());
      end
      if (acc_en || last_hs) chk("acc_en_one_cycle_after_handshake", acc_en, last_hs);
      if (acc_clr)   clr_cnt++;
      if (done)      done_cnt++;
      if (w_ready)   wr_cnt++;
      if (acc_valid) last_av_cyc = cyc;
      last_hs = pix_valid & pix_ready;
    end
  end

  // Accelerator model: one pooled result per nine pixels fed since its last clear.
  int res_plan = 0, res_sent = 0, en_base = 0;
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      acc_valid = 1'b0;
      res_sent  = 0;
    end else if (acc_clr) begin
      acc_valid = 1'b0;
      res_sent  = 0;
      en_base   = acc_en_cnt;
    end else if (res_sent < res_plan && (acc_en_cnt - en_base) >= 9 * (res_sent + 1)
                 && $urandom_range(0, 2) == 0) begin
      acc_valid = 1'b1;
      res_sent++;
    end else begin
      acc_valid = w_ready && ($urandom_range(0, 3) == 0);
    end
  end

  task automatic send_coefs(input int base);
    int j = 0;
    int guard = 0;
    while (j < 9 && guard < 200) begin
      @(posedge clk); #1;
      w_valid = ($urandom_range(0, 3) != 0);
      w_data  = N'(base + j);
      @(negedge clk);
      if (w_valid && w_ready) begin
        exp_k[j] = w_data;
        j++;
      end
      guard++;
    end
    @(posedge clk); #1;
    w_valid = 1'b0;
    if (j < 9) chk("coef_load_timeout", j, 9);
  endtask

  task automatic send_pixels(input int cnt, input int base, input int mode);
    int i = 0;
    int guard = 0;
    while (i < cnt && guard < 2000) begin
      @(posedge clk); #1;
      case (mode)
        0:       pix_valid = 1'b1;
        1:       pix_valid = (guard % 2 == 0);
        default: pix_valid = ($urandom_range(0, 2) != 0);
      endcase
      pix_data = N'(base + i);
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        exp_q.push_back(pix_data);
        i++;
      end
      guard++;
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    if (i < cnt) chk("pixel_stream_timeout", i, cnt);
  endtask

  task automatic start_frame(input logic reuse);
    @(posedge clk); #1;
    start = 1'b1; reuse_k = reuse;
    @(posedge clk); #1;
    start = 1'b0; reuse_k = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("w_ready_after_start", w_ready, !reuse);
    chk("acc_clr_after_start", acc_clr, reuse);
    chk("err_cleared_by_start", err, 0);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (busy) chk("frame_end_timeout", 1, 0);
  endtask

  task automatic check_coefs(input string tag);
    for (int j = 0; j < 9; j++)
      chk($sformatf("%s_k%0d%0d", tag, j / 3, j % 3), kq[j], exp_k[j]);
  endtask

  task automatic run_frame(input logic reuse, input int cbase, input int pbase,
                           input int mode, input int nres, input logic exp_done);
    int en0, clr0, done0, wr0;
    en0 = acc_en_cnt; clr0 = clr_cnt; done0 = done_cnt; wr0 = wr_cnt;
    res_plan = nres;
    start_frame(reuse);
    if (!reuse) send_coefs(cbase);
    send_pixels(PIX_TOTAL, pbase, mode);
    wait_idle();
    chk("acc_en_count", acc_en_cnt - en0, PIX_TOTAL);
    chk("acc_clr_count", clr_cnt - clr0, 1);
    chk("done_count", done_cnt - done0, exp_done ? 1 : 0);
    chk("err_after_frame", err, !exp_done);
    chk("pixels_outstanding", exp_q.size(), 0);
    if (reuse) chk("w_ready_cycles_on_reuse", wr_cnt - wr0, 0);
    if (!exp_done) chk("timeout_min_wait", (cyc - last_av_cyc) >= TMO, 1);
    check_coefs(reuse ? "reuse" : "load");
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_acc_en"}, acc_en, 0);
    chk({tag, "_acc_clr"}, acc_clr, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_w_ready"}, w_ready, 0);
    chk({tag, "_pix_ready"}, pix_ready, 0);
    chk({tag, "_acc_pixel"}, acc_pixel, 0);
    for (int j = 0; j < 9; j++) chk($sformatf("%s_k%0d", tag, j), kq[j], 0);
  endtask

  initial begin
    int clr0, en0;
    rst = 1'b0; start = 1'b0; reuse_k = 1'b0; abort = 1'b0;
    w_valid = 1'b0; w_data = '0; pix_valid = 1'b0; pix_data = '0;
    for (int j = 0; j < 9; j++) exp_k[j] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Coefficients 1..9, pixels 0..35, always-valid source.
    run_frame(1'b0, 1, 0, 0, RES_TOTAL, 1'b1);
    // Reused kernel with a 1/0 toggling source.
    run_frame(1'b1, 0, $urandom_range(0, 1000), 1, RES_TOTAL, 1'b1);
    // Accelerator delivers one result short: timeout.
    run_frame(1'b0, $urandom_range(0, 5000), $urandom_range(0, 1000), 2, RES_TOTAL - 1, 1'b0);
    // Next start clears err.
    run_frame(1'b1, 0, $urandom_range(0, 1000), 2, RES_TOTAL, 1'b1);

    // Abort after 20 accepted pixels.
    clr0 = clr_cnt; en0 = acc_en_cnt;
    res_plan = RES_TOTAL;
    start_frame(1'b1);
    send_pixels(20, $urandom_range(0, 1000), 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_pix_ready", pix_ready, 0);
    chk("abort_acc_clr", acc_clr, 1);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    @(negedge clk);
    chk("abort_acc_clr_single", acc_clr, 0);
    chk("abort_clr_total", clr_cnt - clr0, 2);
    chk("abort_acc_en_total", acc_en_cnt - en0, 20);
    chk("abort_pixels_outstanding", exp_q.size(), 0);
    run_frame(1'b1, 0, $urandom_range(0, 1000), 0, RES_TOTAL, 1'b1);

    // Asynchronous reset in the middle of STREAM.
    res_plan = RES_TOTAL;
    start_frame(1'b0);
    send_coefs($urandom_range(1, 5000));
    send_pixels(10, $urandom_range(0, 1000), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("start_in_reset_busy", busy, 0);
    chk("start_in_reset_w_ready", w_ready, 0);
    chk("start_in_reset_acc_clr", acc_clr, 0);
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.delete();
    for (int j = 0; j < 9; j++) exp_k[j] = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    // Reused kernel after reset must read back as all zeros.
    run_frame(1'b1, 0, $urandom_range(0, 1000), 0, RES_TOTAL, 1'b1);
    run_frame(1'b0, $urandom_range(0, 5000), $urandom_range(0, 1000), 2, RES_TOTAL, 1'b1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cnn_frame_sequencer.md
# cnn_frame_sequencer

Frame-level controller for the CNN accelerator (conv → quantizer → ReLU → pooler). On `start` it loads the nine 3×3 kernel coefficients from a serial weight port, clears the accelerator pipeline, and streams exactly IMG_N² pixels into it under a valid/ready handshake. It then counts pooled results until the full frame has emerged and signals completion, or flags an error on timeout. It sits between the pixel/weight source (DMA or host) and the accelerator instance.

## Interface
- N, 16, pixel / coefficient / result width
- IMG_N, 6, input image side length
- K, 3, kernel side; fixed to 3 (nine coefficient outputs)
- P, 2, pool window side
- TIMEOUT, 64, maximum DRAIN cycles without a pooled result before error
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  frame request, sampled in IDLE only
- reuse_k  in  1  sampled with start; 1 = skip LOAD_K and keep the current coefficients
- abort  in  1  synchronous abort, any state
- w_valid  in  1  coefficient beat valid
- w_data  in  N  coefficient, row-major k00..k22
- w_ready  out  1  high in LOAD_K only
- pix_valid  in  1  source pixel valid
- pix_data  in  N  source pixel
- pix_ready  out  1  high in STREAM only
- acc_clr  out  1  one-cycle pipeline clear to the accelerator, active-high
- acc_en  out  1  registered pixel strobe to the accelerator
- acc_pixel  out  N  registered pixel to the accelerator
- k00..k22  out  N each  coefficient registers, signed
- acc_valid  in  1  accelerator pooled-result valid
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on frame completion
- err  out  1  sticky timeout flag, cleared on the next accepted start

## Operation
- OUT_CNT = ((IMG_N-K+1)/P)²; default 4. PIX_CNT = IMG_N²; default 36.
- States and transitions:
  - IDLE
    - start & !reuse_k → LOAD_K
    - start & reuse_k → CLEAR
  - LOAD_K: each w_valid&w_ready beat writes coefficient index widx (0..8), then widx++. The beat with widx=8 → CLEAR.
  - CLEAR: acc_clr=1 for exactly one cycle; pixel and result counters zeroed → STREAM.
  - STREAM: pix_ready=1. Each pix_valid&pix_ready registers pix_data into acc_pixel and sets acc_en=1 on the next cycle; pcnt++. Acceptance of pixel PIX_CNT-1 → DRAIN.
  - DRAIN: pix_ready=0; timer counts cycles since the last acc_valid. rcnt reaching OUT_CNT → DONE. Timer reaching TIMEOUT → set err, go to IDLE without a done pulse.
  - DONE: done=1 for one cycle → IDLE.
- acc_valid is counted in every state from CLEAR onward, including STREAM. Pooled results may appear before the last pixel is accepted.
- If rcnt reaches OUT_CNT while still in STREAM, no early exit occurs: DRAIN is entered and passes directly to DONE on its first cycle.
- abort: from any non-IDLE state, go to IDLE next cycle and pulse acc_clr once. No done pulse. err is unchanged. Coefficients already written are retained.
- start while busy is ignored.
- acc_valid in IDLE or LOAD_K is ignored.
- Counter widths: clog2(PIX_CNT+1), clog2(OUT_CNT+1), clog2(TIMEOUT+1).

## Timing
- Reset values: all outputs 0, including k00..k22, acc_pixel, and err; state IDLE.
- start → w_ready (or acc_clr when reuse_k=1) high on the next cycle.
- Pixel latency: one cycle from handshake to acc_en/acc_pixel. acc_en is never high for two pixels in one cycle; gaps follow pix_valid gaps.
- The last acc_valid → done has two cycles of latency (DRAIN detect, then DONE).
- Minimum frame time with an always-valid source and reuse_k=1: 1 (CLEAR) + PIX_CNT + accelerator drain + 1.
- Reset mid-frame returns to IDLE immediately (asynchronous) and zeroes the coefficients.

## Structure
- Shared package cnn_pkg:
  - state enum (IDLE, LOAD_K, CLEAR, STREAM, DRAIN, DONE)
  - localparams PIX_CNT, OUT_CNT, NUM_COEF=9
- Sub-module cnn_coef_regs: nine-entry write-indexed coefficient register file with flat k00..k22 outputs. FSM and counters stay in the top module.

## Test plan
- Full frame, reuse_k=0:
  - stimulus: coefficients 1..9, pixels 0..35 always valid, model accelerator returning 4 acc_valid
  - required: k00=1, k22=9; exactly 36 acc_en; one acc_clr; one done; err=0
- Source back-pressure: pix_valid toggling 1/0 → 36 acc_en, each one cycle after its handshake; acc_pixel sequence 0..35 with no loss or duplication.
- reuse_k=1 second frame → no w_ready; acc_clr on the cycle after start; coefficients unchanged.
- Timeout: model returns only 3 results → err=1 after 64 idle DRAIN cycles; no done; next start clears err.
- Abort at pixel 20 → IDLE next cycle; one acc_clr; pix_ready=0; a new start then runs to done with 36 pixels.
- Async reset asserted during STREAM → all outputs and coefficients 0 immediately; start ignored while rst=0.
